// File: rtl/centroid_pkg.sv
// Shared types and default widths for the centroid tracker.
package centroid_pkg;

  localparam int unsigned CW_DEF    = 10;
  localparam int unsigned ACC_W_DEF = 29;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/centroid_div.sv
// Serial restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// o_done is high during the final step, and o_quot then carries the finished quotient.
module centroid_div
  import centroid_pkg::*;
#(
  parameter int unsigned W  = ACC_W_DEF,
  parameter int unsigned QW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [W-1:0]  i_dividend,
  input  logic [W-1:0]  i_divisor,
  output logic          o_done,
  output logic [QW-1:0] o_quot
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem, r_quot, r_den;
  logic [CNT_W-1:0] r_cnt;
  logic [W:0]       w_trial;
  logic             w_ge;
  logic [W-1:0]     w_rem_nxt, w_quot_nxt;

  always_comb begin
    w_trial    = {r_rem, r_quot[W-1]};
    w_ge       = w_trial >= {1'b0, r_den};
    // After a successful subtract the remainder is below the divisor, so W bits suffice.
    w_rem_nxt  = w_ge ? (w_trial[W-1:0] - r_den) : w_trial[W-1:0];
    w_quot_nxt = {r_quot[W-2:0], w_ge};
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_quot = w_quot_nxt[QW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_den  <= i_divisor;
      r_cnt  <= CNT_W'(W);
    end else if (r_cnt != '0) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/centroid_tracker.sv
// Masked-object centroid tracker with per-pixel radius test against the last centroid.
// Define CENTROID_BBOX_EN to add bounding-box outputs bb_xmin/bb_xmax/bb_ymin/bb_ymax.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int unsigned IMG_W   = 720,
  parameter int unsigned IMG_H   = 576,
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MIN_PIX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          vsync,
  input  logic          mask,
  input  logic [CW-1:0] radius,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          centroid_valid,
  output logic          result_stb,
  output logic          busy,
  output logic          overrun,
  output logic          inside_circle,
  output logic [CW-1:0] c_w,
  output logic [CW-1:0] c_h
`ifdef CENTROID_BBOX_EN
  ,
  output logic [CW-1:0] bb_xmin,
  output logic [CW-1:0] bb_xmax,
  output logic [CW-1:0] bb_ymin,
  output logic [CW-1:0] bb_ymax
`endif
);

  state_t              r_state, w_state_d;
  logic                r_vsync, w_eof, w_pix, w_busy, w_take;
  logic                w_start, w_load, w_inval, w_done_x, w_done_y;
  logic [CW-1:0]       r_cur_w, r_cur_h, r_rad, w_qx, w_qy;
  logic [ACC_W-1:0]    r_m00, r_m10, r_m01, r_s00, r_s10, r_s01;
  logic signed [CW:0]  w_dx, w_dy;
  logic [2*CW+1:0]     w_dx2, w_dy2, w_rr, w_rade;

  assign w_eof  = r_vsync & ~vsync;
  assign w_pix  = de & mask;
  assign w_busy = (r_state != IDLE);
  assign w_take = w_eof & ~w_busy;
  assign busy   = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_cur_w <= '0;
      r_cur_h <= '0;
    end else begin
      r_vsync <= vsync;
      if (!vsync) begin
        r_cur_w <= '0;
        r_cur_h <= '0;
      end else if (de) begin
        if (r_cur_w == CW'(IMG_W - 1)) begin
          r_cur_w <= '0;
          r_cur_h <= (r_cur_h == CW'(IMG_H - 1)) ? '0 : r_cur_h + CW'(1);
        end else begin
          r_cur_w <= r_cur_w + CW'(1);
        end
      end
    end
  end

  // A mask pixel coincident with eof seeds the new frame rather than the finished one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m00 <= '0;
      r_m10 <= '0;
      r_m01 <= '0;
      r_s00 <= '0;
      r_s10 <= '0;
      r_s01 <= '0;
      r_rad <= '0;
    end else begin
      if (w_eof) begin
        r_m00 <= ACC_W'(w_pix);
        r_m10 <= w_pix ? ACC_W'(r_cur_w) : '0;
        r_m01 <= w_pix ? ACC_W'(r_cur_h) : '0;
      end else if (w_pix) begin
        r_m00 <= r_m00 + ACC_W'(1);
        r_m10 <= r_m10 + ACC_W'(r_cur_w);
        r_m01 <= r_m01 + ACC_W'(r_cur_h);
      end
      if (w_take) begin
        r_s00 <= r_m00;
        r_s10 <= r_m10;
        r_s01 <= r_m01;
        r_rad <= radius;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_load    = 1'b0;
    w_inval   = 1'b0;
    case (r_state)
      IDLE:   if (w_eof) w_state_d = CHECK;
      CHECK: begin
        if (r_s00 >= ACC_W'(MIN_PIX)) begin
          w_state_d = DIVIDE;
          w_start   = 1'b1;
        end else begin
          w_state_d = DONE;
          w_inval   = 1'b1;
        end
      end
      DIVIDE: begin
        if (w_done_x && w_done_y) begin
          w_state_d = DONE;
          w_load    = 1'b1;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  centroid_div #(.W(ACC_W), .QW(CW)) u_div_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_dividend (r_s10),
    .i_divisor  (r_s00),
    .o_done     (w_done_x),
    .o_quot     (w_qx)
  );

  centroid_div #(.W(ACC_W), .QW(CW)) u_div_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_dividend (r_s01),
    .i_divisor  (r_s00),
    .o_done     (w_done_y),
    .o_quot     (w_qy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x              <= '0;
      y              <= '0;
      centroid_valid <= 1'b0;
      result_stb     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      result_stb <= w_load | w_inval;
      if (w_load) begin
        x              <= w_qx;
        y              <= w_qy;
        centroid_valid <= 1'b1;
      end else if (w_inval) begin
        centroid_valid <= 1'b0;
      end
      if (w_eof && w_busy) overrun <= 1'b1;
    end
  end

  // Unsigned operands widened to signed CW+1 so distances never wrap.
  always_comb begin
    w_dx   = $signed({1'b0, r_cur_w}) - $signed({1'b0, x});
    w_dy   = $signed({1'b0, r_cur_h}) - $signed({1'b0, y});
    w_dx2  = $signed({{(CW + 1){w_dx[CW]}}, w_dx}) * $signed({{(CW + 1){w_dx[CW]}}, w_dx});
    w_dy2  = $signed({{(CW + 1){w_dy[CW]}}, w_dy}) * $signed({{(CW + 1){w_dy[CW]}}, w_dy});
    w_rade = {{(CW + 2){1'b0}}, r_rad};
    w_rr   = w_rade * w_rade;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_circle <= 1'b0;
      c_w           <= '0;
      c_h           <= '0;
    end else begin
      inside_circle <= centroid_valid & ((w_dx2 + w_dy2) <= w_rr);
      c_w           <= r_cur_w;
      c_h           <= r_cur_h;
    end
  end

`ifdef CENTROID_BBOX_EN
  logic          r_bb_any;
  logic [CW-1:0] r_bx0, r_bx1, r_by0, r_by1, r_sx0, r_sx1, r_sy0, r_sy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bb_any <= 1'b0;
      {r_bx0, r_bx1, r_by0, r_by1} <= '0;
      {r_sx0, r_sx1, r_sy0, r_sy1} <= '0;
      {bb_xmin, bb_xmax, bb_ymin, bb_ymax} <= '0;
    end else begin
      if (w_take) begin
        {r_sx0, r_sx1, r_sy0, r_sy1} <= r_bb_any ? {r_bx0, r_bx1, r_by0, r_by1} : '0;
      end
      if (w_eof) begin
        r_bb_any <= w_pix;
        {r_bx0, r_bx1, r_by0, r_by1} <= {r_cur_w, r_cur_w, r_cur_h, r_cur_h};
      end else if (w_pix) begin
        r_bb_any <= 1'b1;
        if (!r_bb_any || r_cur_w < r_bx0) r_bx0 <= r_cur_w;
        if (!r_bb_any || r_cur_w > r_bx1) r_bx1 <= r_cur_w;
        if (!r_bb_any || r_cur_h < r_by0) r_by0 <= r_cur_h;
        if (!r_bb_any || r_cur_h > r_by1) r_by1 <= r_cur_h;
      end
      if (w_load) begin
        {bb_xmin, bb_xmax, bb_ymin, bb_ymax} <= {r_sx0, r_sx1, r_sy0, r_sy1};
      end else if (w_inval) begin
        {bb_xmin, bb_xmax, bb_ymin, bb_ymax} <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// Randomized and directed frames checked against a frame-level centroid model.
module tb_centroid_tracker;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 4;
  localparam int CW      = 10;
  localparam int ACC_W   = 29;
  localparam int MIN_PIX = 1;

  logic          clk = 1'b0;
  logic          rst_n, de, vsync, mask;
  logic [CW-1:0] radius;
  logic [CW-1:0] x, y, c_w, c_h;
  logic          centroid_valid, result_stb, busy, overrun, inside_circle;
`ifdef CENTROID_BBOX_EN
  logic [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
`endif

  always #5 clk = ~clk;

  centroid_tracker #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .ACC_W(ACC_W), .MIN_PIX(MIN_PIX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de             (de),
    .vsync          (vsync),
    .mask           (mask),
    .radius         (radius),
    .x              (x),
    .y              (y),
    .centroid_valid (centroid_valid),
    .result_stb     (result_stb),
    .busy           (busy),
    .overrun        (overrun),
    .inside_circle  (inside_circle),
    .c_w            (c_w),
    .c_h            (c_h)
`ifdef CENTROID_BBOX_EN
    ,
    .bb_xmin        (bb_xmin),
    .bb_xmax        (bb_xmax),
    .bb_ymin        (bb_ymin),
    .bb_ymax        (bb_ymax)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit mask_map [IMG_H][IMG_W];
  int cyc = 0;
  bit prev_vs = 0;
  int acc00, acc10, acc01;
  int mdl_x, mdl_y, mdl_r;
  bit mdl_valid, mdl_ovr;
  int stb_at, busy_from, busy_to;
  bit pend_valid;
  int pend_x, pend_y;
  bit b_any;
  int b_acc [4];
  int b_pend [4];
  int b_out [4];

  task automatic model_clear();
    acc00 = 0; acc10 = 0; acc01 = 0;
    mdl_x = 0; mdl_y = 0; mdl_r = 0; mdl_valid = 0; mdl_ovr = 0;
    stb_at = -1; busy_from = -10; busy_to = -10; prev_vs = 0;
    pend_valid = 0; pend_x = 0; pend_y = 0; b_any = 0;
    for (int i = 0; i < 4; i++) begin b_acc[i] = 0; b_pend[i] = 0; b_out[i] = 0; end
  endtask

  task automatic add_pixel(input int w, input int h);
    acc00 += 1; acc10 += w; acc01 += h;
    if (!b_any) begin
      b_acc[0] = w; b_acc[1] = w; b_acc[2] = h; b_acc[3] = h;
    end else begin
      if (w < b_acc[0]) b_acc[0] = w;
      if (w > b_acc[1]) b_acc[1] = w;
      if (h < b_acc[2]) b_acc[2] = h;
      if (h > b_acc[3]) b_acc[3] = h;
    end
    b_any = 1;
  endtask

  task automatic take_eof(input int k);
    if (k - 1 >= busy_from && k - 1 <= busy_to) begin
      mdl_ovr = 1;
    end else begin
      busy_from = k;
      if (acc00 >= MIN_PIX) begin
        stb_at = k + ACC_W + 1;
        pend_valid = 1;
        pend_x = (acc10 / acc00) % (1 << CW);
        pend_y = (acc01 / acc00) % (1 << CW);
      end else begin
        stb_at = k + 1;
        pend_valid = 0;
      end
      busy_to = stb_at;
      mdl_r = int'(radius);
      for (int i = 0; i < 4; i++) b_pend[i] = b_any ? b_acc[i] : 0;
    end
    acc00 = 0; acc10 = 0; acc01 = 0; b_any = 0;
  endtask

  task automatic publish();
    mdl_valid = pend_valid;
    if (pend_valid) begin mdl_x = pend_x; mdl_y = pend_y; end
    for (int i = 0; i < 4; i++) b_out[i] = pend_valid ? b_pend[i] : 0;
  endtask

  task automatic step(input bit d, input bit vs, input bit m, input int w, input int h);
    int k, dx, dy;
    bit exp_in;
    k = cyc + 1;
    dx = w - mdl_x;
    dy = h - mdl_y;
    exp_in = mdl_valid && (dx * dx + dy * dy <= mdl_r * mdl_r);
    if (prev_vs && !vs) take_eof(k);
    if (d && m) add_pixel(w, h);
    de = d; vsync = vs; mask = m; prev_vs = vs;
    @(negedge clk);
    cyc = k;
    if (cyc == stb_at) publish();
    check_eq("result_stb", result_stb, 32'(cyc == stb_at));
    check_eq("busy", busy, 32'(cyc >= busy_from && cyc <= busy_to));
    check_eq("centroid_valid", centroid_valid, mdl_valid);
    check_eq("x", x, mdl_x);
    check_eq("y", y, mdl_y);
    check_eq("overrun", overrun, mdl_ovr);
    if (d) begin
      check_eq("inside_circle", inside_circle, exp_in);
      check_eq("c_w", c_w, w);
      check_eq("c_h", c_h, h);
    end
`ifdef CENTROID_BBOX_EN
    check_eq("bb_xmin", bb_xmin, b_out[0]);
    check_eq("bb_xmax", bb_xmax, b_out[1]);
    check_eq("bb_ymin", bb_ymin, b_out[2]);
    check_eq("bb_ymax", bb_ymax, b_out[3]);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; de = 0; vsync = 0; mask = 0; radius = '0;
    repeat (3) @(negedge clk);
    check_eq("rst x", x, 0);
    check_eq("rst y", y, 0);
    check_eq("rst valid", centroid_valid, 0);
    check_eq("rst stb", result_stb, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst overrun", overrun, 0);
    check_eq("rst inside", inside_circle, 0);
    check_eq("rst c_w", c_w, 0);
    check_eq("rst c_h", c_h, 0);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic clear_map();
    for (int h = 0; h < IMG_H; h++)
      for (int w = 0; w < IMG_W; w++) mask_map[h][w] = 0;
  endtask

  task automatic run_frame(input int rad, input int blank, input int gap_pct, input bit eof_pix);
    radius = CW'(rad);
    for (int h = 0; h < IMG_H; h++) begin
      for (int w = 0; w < IMG_W; w++) begin
        while ($urandom_range(99) < gap_pct) step(0, 1, 0, 0, 0);
        step(1, 1, mask_map[h][w], w, h);
      end
    end
    step(eof_pix, 0, eof_pix, 0, 0);
    for (int i = 1; i < blank; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Centroid (3,2) from two pixels, radius 1 for the next frame
    clear_map();
    mask_map[1][2] = 1; mask_map[3][4] = 1;
    run_frame(1, 40, 0, 0);

    // Empty frame: inside_circle tested against (3,2) r=1, then result invalid, x/y held
    clear_map();
    run_frame(3, 40, 0, 0);

    // Pixel coincident with eof belongs to the following frame
    clear_map();
    mask_map[3][5] = 1;
    run_frame(2, 40, 10, 1);
    run_frame(2, 40, 10, 0);

    // Bounding-box corners
    clear_map();
    mask_map[0][1] = 1; mask_map[3][6] = 1;
    run_frame(4, 40, 0, 0);

    for (int f = 0; f < 8; f++) begin
      int dens;
      dens = (f == 3) ? 0 : $urandom_range(60);
      for (int h = 0; h < IMG_H; h++)
        for (int w = 0; w < IMG_W; w++) mask_map[h][w] = ($urandom_range(99) < dens);
      run_frame($urandom_range(9), $urandom_range(60, 35), 20, 0);
    end

    // Second eof five cycles after the first
    clear_map();
    mask_map[2][6] = 1; mask_map[0][0] = 1;
    run_frame(2, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0);

    // Reset ten cycles into the division, then a clean frame
    clear_map();
    mask_map[1][7] = 1; mask_map[2][3] = 1; mask_map[3][2] = 1;
    run_frame(1, 11, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    run_frame(2, 40, 0, 0);
    run_frame(2, 40, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centroid_tracker.md
CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameter IMG_W, default 720, active pixels per line.
REQ-002 Parameter IMG_H, default 576, active lines per frame.
REQ-003 Parameter CW, default 10, coordinate width.
REQ-004 Parameter ACC_W, default 29, moment accumulator and divider width.
REQ-005 Parameter MIN_PIX, default 64, minimum mask-pixel count for a valid centroid.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 de  in  1  active-pixel enable.
REQ-009 vsync  in  1  high during frame; falling edge marks end of frame (eof).
REQ-010 mask  in  1  pixel belongs to object; qualified by de.
REQ-011 radius  in  CW  marker radius, sampled at eof.
REQ-012 x, y  out  CW  latched centroid.
REQ-013 centroid_valid  out  1  latched centroid from last completed frame is valid.
REQ-014 result_stb  out  1  one-cycle pulse when x/y/centroid_valid update.
REQ-015 busy  out  1  division in progress.
REQ-016 overrun  out  1  sticky; eof arrived while busy.
REQ-017 inside_circle  out  1  current pixel within radius of centroid; registered.
REQ-018 c_w, c_h  out  CW  pixel coordinates aligned with inside_circle.

Function
REQ-019 Counters: vsync=0 clears cur_w/cur_h; de=1 increments cur_w; at IMG_W-1 wraps to 0 and increments cur_h; cur_h wraps at IMG_H-1.
REQ-020 eof = vsync registered 1 AND vsync 0, one cycle.
REQ-021 Accumulate per de&mask pixel: m00+=1, m10+=cur_w, m01+=cur_h, all ACC_W wide, no saturation.
REQ-022 At eof: snapshot m00/m10/m01 and radius; clear accumulators same cycle; a de&mask pixel coincident with eof is counted in the new frame.
REQ-023 FSM IDLE->CHECK on eof; CHECK->DIVIDE if m00>=MIN_PIX, else CHECK->DONE with centroid_valid<=0.
REQ-024 DIVIDE: x and y quotients computed in parallel, restoring, one bit per cycle, exactly ACC_W cycles; then DONE.
REQ-025 DONE: load x=m10/m00[CW-1:0], y=m01/m00[CW-1:0], centroid_valid<=1, result_stb=1; ->IDLE.
REQ-026 Latency eof to result_stb: ACC_W+2 cycles when dividing, 2 cycles when below MIN_PIX.
REQ-027 busy=1 in CHECK, DIVIDE, DONE.
REQ-028 eof while busy: ignored for division, snapshot kept, accumulators still cleared, overrun<=1 until reset.
REQ-029 Below MIN_PIX (including m00=0): x,y hold previous values; no division by zero performed.
REQ-030 inside_circle <= centroid_valid AND (dx*dx+dy*dy <= r*r); dx=cur_w-x, dy=cur_h-y signed CW+1 bits, products 2*CW+2 bits, no wrap-around.
REQ-031 inside_circle, c_w, c_h registered together, one cycle after pixel coordinates are valid.

Reset
REQ-032 rst_n low: counters, accumulators, snapshots, x, y, c_w, c_h = 0; centroid_valid, result_stb, busy, overrun, inside_circle = 0; FSM=IDLE.
REQ-033 Reset mid-division aborts; no result_stb issued; first eof after release starts fresh.

Configuration
REQ-034 Macro CENTROID_BBOX_EN defined: adds outputs bb_xmin, bb_xmax, bb_ymin, bb_ymax (CW each), tracked over de&mask pixels, latched at DONE with x/y; all zero when centroid_valid=0.
REQ-035 Macro undefined: bounding-box ports and logic absent; all other behaviour identical.

Structure
REQ-036 Shared package centroid_pkg: FSM state enum (IDLE, CHECK, DIVIDE, DONE), default widths CW/ACC_W.
REQ-037 One sub-module centroid_div: serial restoring ACC_W-bit unsigned divider, start/done handshake, instantiated twice.

Verification
REQ-038 IMG_W=8, IMG_H=4, MIN_PIX=1, mask only at (2,1),(4,3) -> after eof result_stb at ACC_W+2 cycles, x=3, y=2, centroid_valid=1.
REQ-039 Frame with 0 mask pixels -> result_stb 2 cycles after eof, centroid_valid=0, x/y unchanged.
REQ-040 Centroid (3,2), radius=1 -> next frame inside_circle=1 exactly at (3,2),(2,2),(4,2),(3,1),(3,3); 0 at (0,0) (no wrap).
REQ-041 Second eof 5 cycles after first -> overrun=1, first frame result still delivered, no second result_stb.
REQ-042 rst_n low 10 cycles into DIVIDE -> all outputs 0, no result_stb; next full frame produces correct centroid.
REQ-043 CENTROID_BBOX_EN, mask at (1,0),(6,3) -> bb_xmin=1, bb_xmax=6, bb_ymin=0, bb_ymax=3.
